// File: rtl/baccarat_pkg.sv
// ============================================================================
// baccarat_pkg : shared state encoding, thresholds and card-value helper
// Revision     : 1.0
// ============================================================================
`default_nettype none

package baccarat_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    DEAL_P1  = 4'd1,
    DEAL_D1  = 4'd2,
    DEAL_P2  = 4'd3,
    DEAL_D2  = 4'd4,
    EVAL_NAT = 4'd5,
    DEAL_P3  = 4'd6,
    EVAL_D3  = 4'd7,
    DEAL_D3  = 4'd8,
    DONE     = 4'd9
  } state_t;

  localparam logic [3:0] NATURAL_MIN     = 4'd8;
  localparam logic [3:0] PLAYER_DRAW_MAX = 4'd5;

  // Tens and face cards count as zero.
  function automatic logic [3:0] card_value(input logic [3:0] code);
    return (code >= 4'd10) ? 4'd0 : code;
  endfunction

endpackage

`default_nettype wire

// File: rtl/banker_draw_rule.sv
// ============================================================================
// banker_draw_rule : banker third-card decision after the player has drawn
// Revision         : 1.0
// ============================================================================
`default_nettype none

module banker_draw_rule (
  input  logic [3:0] dscore,
  input  logic [3:0] v,
  output logic       draw
);

  always_comb begin
    draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (v != 4'd8);
      4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
      4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
      4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
      default:          draw = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/baccarat_sequencer.sv
// ============================================================================
// baccarat_sequencer : dealing-order / third-card controller for the baccarat
//                      datapath. Optional macro BACCARAT_STEP_EN adds a step gate.
// Revision           : 1.0
// ============================================================================
`default_nettype none

module baccarat_sequencer
  import baccarat_pkg::*;
#(
  parameter bit TIE_BOTH_LIGHTS = 1'b1
) (
  input  logic       slow_clock,
  input  logic       resetb,
`ifdef BACCARAT_STEP_EN
  input  logic       step,
`endif
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic       hand_done
);

  state_t state;
  state_t nxt;
  logic   adv;
  logic   banker_draw;

`ifdef BACCARAT_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  banker_draw_rule u_banker_draw_rule (
    .dscore (dscore),
    .v      (card_value(pcard3)),
    .draw   (banker_draw)
  );

  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (adv) nxt = DEAL_P1;
      DEAL_P1:  if (adv) nxt = DEAL_D1;
      DEAL_D1:  if (adv) nxt = DEAL_P2;
      DEAL_P2:  if (adv) nxt = DEAL_D2;
      DEAL_D2:  if (adv) nxt = EVAL_NAT;
      EVAL_NAT: if (adv) begin
        if (pscore >= NATURAL_MIN || dscore >= NATURAL_MIN) nxt = DONE;
        else if (pscore <= PLAYER_DRAW_MAX)                 nxt = DEAL_P3;
        // Player stands: banker draws on the same 0-5 threshold.
        else if (dscore <= PLAYER_DRAW_MAX)                 nxt = DEAL_D3;
        else                                                nxt = DONE;
      end
      DEAL_P3:  if (adv) nxt = EVAL_D3;
      EVAL_D3:  if (adv) nxt = banker_draw ? DEAL_D3 : DONE;
      DEAL_D3:  if (adv) nxt = DONE;
      DONE:     nxt = DONE;
      default:  nxt = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they track the state register exactly.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state       <= IDLE;
      load_pcard1 <= 1'b0;
      load_dcard1 <= 1'b0;
      load_pcard2 <= 1'b0;
      load_dcard2 <= 1'b0;
      load_pcard3 <= 1'b0;
      load_dcard3 <= 1'b0;
      hand_done   <= 1'b0;
    end else begin
      state       <= nxt;
      load_pcard1 <= (nxt == DEAL_P1);
      load_dcard1 <= (nxt == DEAL_D1);
      load_pcard2 <= (nxt == DEAL_P2);
      load_dcard2 <= (nxt == DEAL_D2);
      load_pcard3 <= (nxt == DEAL_P3);
      load_dcard3 <= (nxt == DEAL_D3);
      hand_done   <= (nxt == DONE);
    end
  end

  always_comb begin
    player_win_light = 1'b0;
    dealer_win_light = 1'b0;
    if (hand_done) begin
      if (pscore > dscore) begin
        player_win_light = 1'b1;
      end else if (dscore > pscore) begin
        dealer_win_light = 1'b1;
      end else begin
        player_win_light = TIE_BOTH_LIGHTS;
        dealer_win_light = TIE_BOTH_LIGHTS;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_baccarat_sequencer.sv
// ============================================================================
// tb_baccarat_sequencer : directed self-checking bench for baccarat_sequencer
// Revision              : 1.0
// ============================================================================
`default_nettype none

module tb_baccarat_sequencer;

  logic       slow_clock = 1'b0;
  logic       resetb     = 1'b0;
  logic [3:0] pscore     = 4'd0;
  logic [3:0] dscore     = 4'd0;
  logic [3:0] pcard3     = 4'd0;
`ifdef BACCARAT_STEP_EN
  logic       step       = 1'b1;
`endif

  logic lp1, lp2, lp3, ld1, ld2, ld3, pwin, dwin, done;
  logic lp1_b, lp2_b, lp3_b, ld1_b, ld2_b, ld3_b, pwin_b, dwin_b, done_b;
  logic [3:0] rule_d, rule_v;
  logic       rule_draw;

  int total = 0;
  int bad   = 0;

  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_P1   = 6'b100000;
  localparam logic [5:0] S_D1   = 6'b010000;
  localparam logic [5:0] S_P2   = 6'b001000;
  localparam logic [5:0] S_D2   = 6'b000100;
  localparam logic [5:0] S_P3   = 6'b000010;
  localparam logic [5:0] S_D3   = 6'b000001;

  always #5 slow_clock = ~slow_clock;

  baccarat_sequencer #(.TIE_BOTH_LIGHTS(1'b1)) dut (
    .slow_clock       (slow_clock),
    .resetb           (resetb),
`ifdef BACCARAT_STEP_EN
    .step             (step),
`endif
    .pscore           (pscore),
    .dscore           (dscore),
    .pcard3           (pcard3),
    .load_pcard1      (lp1),
    .load_pcard2      (lp2),
    .load_pcard3      (lp3),
    .load_dcard1      (ld1),
    .load_dcard2      (ld2),
    .load_dcard3      (ld3),
    .player_win_light (pwin),
    .dealer_win_light (dwin),
    .hand_done        (done)
  );

  baccarat_sequencer #(.TIE_BOTH_LIGHTS(1'b0)) dut_notie (
    .slow_clock       (slow_clock),
    .resetb           (resetb),
`ifdef BACCARAT_STEP_EN
    .step             (step),
`endif
    .pscore           (pscore),
    .dscore           (dscore),
    .pcard3           (pcard3),
    .load_pcard1      (lp1_b),
    .load_pcard2      (lp2_b),
    .load_pcard3      (lp3_b),
    .load_dcard1      (ld1_b),
    .load_dcard2      (ld2_b),
    .load_dcard3      (ld3_b),
    .player_win_light (pwin_b),
    .dealer_win_light (dwin_b),
    .hand_done        (done_b)
  );

  banker_draw_rule u_rule (
    .dscore (rule_d),
    .v      (rule_v),
    .draw   (rule_draw)
  );

  function automatic logic [5:0] strobes();
    return {lp1, ld1, lp2, ld2, lp3, ld3};
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge slow_clock);
    #1;
  endtask

  task automatic cyc(input string tag, input logic [5:0] exp_s, input logic exp_done);
    tick();
    chk({tag, " strobes"}, {2'b00, strobes()}, {2'b00, exp_s});
    chk({tag, " done"}, {7'd0, done}, {7'd0, exp_done});
  endtask

  task automatic lights(input string tag, input logic ep, input logic ed,
                        input logic ep0, input logic ed0);
    chk({tag, " lights"},      {6'd0, pwin, dwin},     {6'd0, ep, ed});
    chk({tag, " lights_tie0"}, {6'd0, pwin_b, dwin_b}, {6'd0, ep0, ed0});
  endtask

  // Reset, release with IDLE as cycle 0, then walk the fixed deal into EVAL_NAT (cycle 5).
  task automatic start_hand(input string tag, input logic [3:0] ps, input logic [3:0] ds,
                            input logic [3:0] c3);
    @(negedge slow_clock);
    resetb = 1'b0;
    pscore = ps;
    dscore = ds;
    pcard3 = c3;
    #1;
    chk({tag, " rst"}, {1'b0, strobes(), done}, 8'd0);
    #1;
    resetb = 1'b1;
    #1;
    chk({tag, " c0"}, {1'b0, strobes(), done}, 8'd0);
    cyc({tag, " c1"}, S_P1, 1'b0);
    cyc({tag, " c2"}, S_D1, 1'b0);
    cyc({tag, " c3"}, S_P2, 1'b0);
    cyc({tag, " c4"}, S_D2, 1'b0);
    cyc({tag, " c5"}, S_NONE, 1'b0);
  endtask

  logic [9:0] draw_tbl [10];

  initial begin
    // Row d: bit v set when the banker draws with score d against player third card v.
    draw_tbl[0] = 10'b1111111111;
    draw_tbl[1] = 10'b1111111111;
    draw_tbl[2] = 10'b1111111111;
    draw_tbl[3] = 10'b1011111111;
    draw_tbl[4] = 10'b0011111100;
    draw_tbl[5] = 10'b0011110000;
    draw_tbl[6] = 10'b0011000000;
    draw_tbl[7] = 10'b0000000000;
    draw_tbl[8] = 10'b0000000000;
    draw_tbl[9] = 10'b0000000000;

    for (int d = 0; d < 10; d++) begin
      for (int v = 0; v < 10; v++) begin
        rule_d = 4'(d);
        rule_v = 4'(v);
        #1;
        chk($sformatf("rule d%0d v%0d", d, v), {7'd0, rule_draw}, {7'd0, draw_tbl[d][v]});
      end
    end

    // Natural for player.
    start_hand("nat", 4'd9, 4'd3, 4'd0);
    cyc("nat c6", S_NONE, 1'b1);
    lights("nat", 1'b1, 1'b0, 1'b1, 1'b0);
    cyc("nat hold", S_NONE, 1'b1);

    // Player stands on 7, banker draws.
    start_hand("stand", 4'd7, 4'd4, 4'd0);
    cyc("stand c6", S_D3, 1'b0);
    dscore = 4'd5;
    cyc("stand c7", S_NONE, 1'b1);
    lights("stand", 1'b1, 1'b0, 1'b1, 1'b0);

    // Player stands on 6, banker stands on 7.
    start_hand("both", 4'd6, 4'd7, 4'd0);
    cyc("both c6", S_NONE, 1'b1);
    lights("both", 1'b0, 1'b1, 1'b0, 1'b1);

    // Player draws a 7, banker on 6 draws.
    start_hand("pd7", 4'd3, 4'd6, 4'd7);
    cyc("pd7 c6", S_P3, 1'b0);
    cyc("pd7 c7", S_NONE, 1'b0);
    cyc("pd7 c8", S_D3, 1'b0);
    cyc("pd7 c9", S_NONE, 1'b1);
    lights("pd7", 1'b0, 1'b1, 1'b0, 1'b1);

    // Player draws a queen (value 0), banker on 6 stands.
    start_hand("pdq", 4'd3, 4'd6, 4'd12);
    cyc("pdq c6", S_P3, 1'b0);
    cyc("pdq c7", S_NONE, 1'b0);
    cyc("pdq c8", S_NONE, 1'b1);

    // Tie on 5: player draws an ace, banker on 5 stands.
    start_hand("tie", 4'd5, 4'd5, 4'd1);
    cyc("tie c6", S_P3, 1'b0);
    cyc("tie c7", S_NONE, 1'b0);
    cyc("tie c8", S_NONE, 1'b1);
    lights("tie", 1'b1, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset during DEAL_P2.
    start_hand("arst", 4'd9, 4'd9, 4'd0);
    start_hand("arst2", 4'd2, 4'd2, 4'd0);
    @(negedge slow_clock);
    resetb = 1'b0;
    @(negedge slow_clock);
    resetb = 1'b1;
    cyc("arst c1", S_P1, 1'b0);
    cyc("arst c2", S_D1, 1'b0);
    cyc("arst c3", S_P2, 1'b0);
    #2;
    resetb = 1'b0;
    #1;
    chk("arst drop", {2'b00, strobes()}, 8'd0);
    @(negedge slow_clock);
    resetb = 1'b1;
    cyc("arst re1", S_P1, 1'b0);

`ifdef BACCARAT_STEP_EN
    @(negedge slow_clock);
    resetb = 1'b0;
    step = 1'b1;
    @(negedge slow_clock);
    resetb = 1'b1;
    cyc("step c1", S_P1, 1'b0);
    cyc("step c2", S_D1, 1'b0);
    step = 1'b0;
    for (int i = 0; i < 5; i++) cyc($sformatf("step hold%0d", i), S_D1, 1'b0);
    step = 1'b1;
    cyc("step go", S_P2, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
